tx_sched: RTL

TX_SCHED -- requirements
Module: tx_sched

---
 rtl/tx_sched_pkg.sv | 18 +
 rtl/tx_sched_if.sv | 33 +++
 rtl/tx_sched_rr_arb2.sv | 34 +++
 rtl/tx_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding,
// requester indices and per-requester byte counts.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

    localparam logic REQ_IDX0 = 1'b0;
    localparam logic REQ_IDX1 = 1'b1;

    localparam logic [1:0] BYTES_REQ0 = 2'd1;
    localparam logic [1:0] BYTES_REQ1 = 2'd2;

endpackage

// File: rtl/tx_sched_if.sv
// Signal bundle between the two requesters, the UART transmitter and the
// scheduler. The slave modport is the scheduler's view.
interface tx_sched_if
    import tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    // Requesters raise reqN_vld with stable data and hold both until the
    // one-cycle reqN_ack pulse; the word is captured on the grant edge.
    logic                    req0_vld;
    logic [DATA_WIDTH-1:0]   req0_data;
    logic                    req0_ack;
    logic                    req1_vld;
    logic [2*DATA_WIDTH-1:0] req1_data;
    logic                    req1_ack;
    logic                    tx_busy;
    logic [DATA_WIDTH-1:0]   tx_p_data;
    logic                    tx_d_vld;
    logic                    sched_busy;
    logic                    tx_err;
    sched_state_t            state;

    modport slave (
        input  req0_vld, req0_data, req1_vld, req1_data, tx_busy,
        output req0_ack, req1_ack, tx_p_data, tx_d_vld, sched_busy, tx_err, state
    );

    modport master (
        output req0_vld, req0_data, req1_vld, req1_data, tx_busy,
        input  req0_ack, req1_ack, tx_p_data, tx_d_vld, sched_busy, tx_err, state
    );

endinterface

// File: rtl/tx_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins a tie and flips away from whoever was granted when en is high.
module rr_arb2
    import tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic ptr_q;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = REQ_IDX0;
        if (req == 2'b11) begin
            gnt_idx = ptr_q;
        end else if (req[1]) begin
            gnt_idx = REQ_IDX1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_IDX0;
        end else if (en && gnt_vld) begin
            ptr_q <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/tx_sched.sv
// Feeds bytes from a one-byte and a two-byte requester into a UART
// transmitter, one strobe per byte, with a timeout on the transmitter start.
module tx_sched
    import tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    tx_sched_if.slave  bus
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    sched_state_t            state_q, state_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic [1:0]              bytes_q, bytes_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ack0_q, ack0_d, ack1_q, ack1_d;
    logic                    vld_q, vld_d, err_q, err_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    gnt_vld, gnt_idx, gnt_en;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.req1_vld, bus.req0_vld}),
        .en      (gnt_en),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            bytes_q <= '0;
            cnt_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    // Every output is computed for the state being entered, so the strobe,
    // ack and byte all appear together in the LOAD cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bytes_d = bytes_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        gnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.tx_busy && gnt_vld) begin
                    gnt_en  = 1'b1;
                    vld_d   = 1'b1;
                    state_d = ST_LOAD;
                    if (gnt_idx == REQ_IDX1) begin
                        hold_d  = bus.req1_data;
                        bytes_d = BYTES_REQ1;
                        data_d  = bus.req1_data[DATA_WIDTH-1:0];
                        ack1_d  = 1'b1;
                    end else begin
                        hold_d  = {{DATA_WIDTH{1'b0}}, bus.req0_data};
                        bytes_d = BYTES_REQ0;
                        data_d  = bus.req0_data;
                        ack0_d  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    bytes_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    bytes_d = bytes_q - 2'd1;
                    if (bytes_q > 2'd1) begin
                        // Only a two-byte word gets here; the high byte goes second.
                        data_d  = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        vld_d   = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.req0_ack   = ack0_q;
    assign bus.req1_ack   = ack1_q;
    assign bus.tx_d_vld   = vld_q;
    assign bus.tx_p_data  = data_q;
    assign bus.tx_err     = err_q;
    assign bus.sched_busy = busy_q;
    assign bus.state      = state_q;

endmodule
